somador_bcd_serial_n: RTL and testbench

SOMADOR_BCD_SERIAL_N -- requirements
Module: somador_bcd_serial_n

---
 rtl/somador_bcd_serial_n.sv | 135 +++++++++++++
 tb/tb_somador_bcd_serial_n.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/somador_bcd_serial_n.sv
// Serial BCD adder/subtractor: one decimal digit per clock, least significant first.
// Subtraction is performed as A + nines-complement(B) + 1, i.e. A + 10^N - B.
module somador_bcd_serial_n #(
    parameter int N_DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic [4*N_DIGITS-1:0] a,
    input  logic [4*N_DIGITS-1:0] b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*N_DIGITS-1:0] sum,
    output logic                  cout,
    output logic                  invalid
);

    localparam int W     = 4 * N_DIGITS;
    localparam int IDX_W = (N_DIGITS < 2) ? 1 : $clog2(N_DIGITS);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    // One decimal digit add: returns {carry_out, digit}.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] x,
                                                 input logic [3:0] y,
                                                 input logic       c);
        logic [4:0] t;
        t = {1'b0, x} + {1'b0, y} + {4'd0, c};
        if (t > 5'd9)
            return {1'b1, t[3:0] + 4'd6};
        else
            return {1'b0, t[3:0]};
    endfunction

    function automatic logic has_non_bcd(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < N_DIGITS; i++)
            if (v[4*i +: 4] > 4'd9)
                bad = 1'b1;
        return bad;
    endfunction

    state_t           state, state_nxt;
    logic [W-1:0]     a_sh, b_sh, res_sh, res_next;
    logic             sub_r, carry, bad_r, last;
    logic [IDX_W-1:0] idx;
    logic [3:0]       b_eff;
    logic [4:0]       dsum;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == RUN);
    end

    assign last  = (idx == IDX_W'(N_DIGITS - 1));
    assign b_eff = sub_r ? (4'd9 - b_sh[3:0]) : b_sh[3:0];
    assign dsum  = bcd_digit_add(a_sh[3:0], b_eff, carry);

    // Result digits enter at the top and drift down, so after N shifts digit 0 sits at the bottom.
    generate
        if (N_DIGITS == 1) begin : g_one
            assign res_next = dsum[3:0];
        end else begin : g_many
            assign res_next = {dsum[3:0], res_sh[W-1:4]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            sub_r   <= 1'b0;
            carry   <= 1'b0;
            bad_r   <= 1'b0;
            idx     <= '0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            invalid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_sh  <= a;
                    b_sh  <= b;
                    sub_r <= sub;
                    carry <= sub ? 1'b1 : cin;
                    bad_r <= has_non_bcd(a) | has_non_bcd(b);
                    idx   <= '0;
                end
            end else begin
                a_sh   <= a_sh >> 4;
                b_sh   <= b_sh >> 4;
                res_sh <= res_next;
                carry  <= dsum[4];
                idx    <= idx + IDX_W'(1);
                if (last) begin
                    done <= 1'b1;
                    if (bad_r) begin
                        sum     <= '0;
                        cout    <= 1'b0;
                        invalid <= 1'b1;
                    end else begin
                        sum     <= res_next;
                        cout    <= dsum[4];
                        invalid <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_somador_bcd_serial_n.sv
// Directed bench for the serial BCD adder (N=3) plus random sweeps at N=1 and N=8.
module tb_somador_bcd_serial_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start3 = 0, sub3 = 0, cin3 = 0;
    logic [11:0] a3 = 0, b3 = 0;
    logic        busy3, done3, cout3, inv3;
    logic [11:0] sum3;

    logic        start1 = 0, sub1 = 0, cin1 = 0;
    logic [3:0]  a1 = 0, b1 = 0;
    logic        busy1, done1, cout1, inv1;
    logic [3:0]  sum1;

    logic        start8 = 0, sub8 = 0, cin8 = 0;
    logic [31:0] a8 = 0, b8 = 0;
    logic        busy8, done8, cout8, inv8;
    logic [31:0] sum8;

    int checks = 0;
    int errors = 0;

    somador_bcd_serial_n #(.N_DIGITS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .sub(sub3), .a(a3), .b(b3), .cin(cin3),
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .invalid(inv3));
    somador_bcd_serial_n #(.N_DIGITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .invalid(inv1));
    somador_bcd_serial_n #(.N_DIGITS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .invalid(inv8));

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint to_bcd(input longint v, input int nd);
        longint r = 0;
        for (int i = 0; i < nd; i++) begin
            r = r | ((v % 10) << (4 * i));
            v = v / 10;
        end
        return r;
    endfunction

    // Launches one N=3 operation; if now=0 it first aligns to a falling edge.
    task automatic op3(input string tag, input bit now, input logic [11:0] ta, input logic [11:0] tb,
                       input logic ts, input logic tc,
                       input logic [11:0] es, input logic ec, input logic ei);
        int lat;
        if (!now) @(negedge clk);
        a3 = ta; b3 = tb; sub3 = ts; cin3 = tc; start3 = 1;
        @(posedge clk); #1;
        start3 = 0;
        check({tag, "_busy"}, busy3, 1);
        lat = 0;
        while (!done3 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 3);
        check({tag, "_sum"}, sum3, es);
        check({tag, "_cout"}, cout3, ec);
        check({tag, "_inv"}, inv3, ei);
        check({tag, "_busy_done"}, busy3, 0);
    endtask

    task automatic op1(input logic [3:0] ta, input logic [3:0] tb, input logic ts, input logic tc,
                       input longint es, input longint ec);
        int lat;
        @(negedge clk);
        a1 = ta; b1 = tb; sub1 = ts; cin1 = tc; start1 = 1;
        @(posedge clk); #1;
        start1 = 0;
        lat = 0;
        while (!done1 && lat < 5) begin
            @(posedge clk); #1;
            lat++;
        end
        check("n1_lat", lat, 1);
        check("n1_res", {cout1, sum1}, (ec << 4) | es);
    endtask

    task automatic op8(input logic [31:0] ta, input logic [31:0] tb, input logic ts, input logic tc,
                       input longint es, input longint ec);
        int lat;
        @(negedge clk);
        a8 = ta; b8 = tb; sub8 = ts; cin8 = tc; start8 = 1;
        @(posedge clk); #1;
        start8 = 0;
        lat = 0;
        while (!done8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("n8_lat", lat, 8);
        check("n8_res", {cout8, sum8}, (ec << 32) | es);
    endtask

    initial begin
        longint va, vb, vc, tot, md;
        int lat;
        bit seen;

        #1;
        check("rst_busy", busy3, 0);
        check("rst_done", done3, 0);
        check("rst_sum", sum3, 0);
        check("rst_cout", cout3, 0);
        check("rst_inv", inv3, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        op3("carry_chain", 0, 12'h999, 12'h001, 0, 0, 12'h000, 1, 0);
        op3("cin_add", 0, 12'h349, 12'h650, 0, 1, 12'h000, 1, 0);
        op3("plain_add", 0, 12'h015, 12'h027, 0, 0, 12'h042, 0, 0);
        op3("max_add", 0, 12'h999, 12'h999, 0, 1, 12'h999, 1, 0);
        op3("sub_pos", 0, 12'h500, 12'h499, 1, 0, 12'h001, 1, 0);
        op3("sub_neg", 0, 12'h000, 12'h001, 1, 1, 12'h999, 0, 0);
        op3("bad_op", 0, 12'h0A5, 12'h001, 0, 0, 12'h000, 0, 1);
        op3("after_bad", 0, 12'h001, 12'h001, 0, 0, 12'h002, 0, 0);

        // start while busy must be ignored
        @(negedge clk);
        a3 = 12'h123; b3 = 12'h456; sub3 = 0; cin3 = 0; start3 = 1;
        @(negedge clk);
        start3 = 0;
        @(negedge clk);
        a3 = 12'h900; b3 = 12'h900; sub3 = 1; start3 = 1;
        @(negedge clk);
        start3 = 0;
        lat = 0;
        while (!done3 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ign_sum", sum3, 12'h579);
        check("ign_cout", cout3, 0);
        @(posedge clk); #1;
        check("ign_no_restart", busy3, 0);
        check("done_pulse_once", done3, 0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_sum", sum3, 12'h579);

        // start during done cycle: back-to-back
        op3("b2b_first", 0, 12'h100, 12'h200, 0, 0, 12'h300, 0, 0);
        op3("b2b_second", 1, 12'h250, 12'h250, 0, 0, 12'h500, 0, 0);

        // reset mid-RUN
        @(negedge clk);
        a3 = 12'h111; b3 = 12'h111; sub3 = 0; cin3 = 0; start3 = 1;
        @(posedge clk); #1;
        start3 = 0;
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        check("mrst_busy", busy3, 0);
        check("mrst_done", done3, 0);
        check("mrst_sum", sum3, 0);
        check("mrst_cout", cout3, 0);
        check("mrst_inv", inv3, 0);
        @(negedge clk);
        rst_n = 1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done3) seen = 1;
        end
        check("mrst_no_done", seen, 0);
        op3("post_rst", 0, 12'h040, 12'h060, 0, 0, 12'h100, 0, 0);

        // random sweeps against integer arithmetic
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 200; i++) begin
                va = $urandom_range(0, 9);
                vb = $urandom_range(0, 9);
                vc = $urandom_range(0, 1);
                if (m == 0) begin
                    tot = va + vb + vc;
                    op1(4'(va), 4'(vb), 0, 1'(vc), to_bcd(tot % 10, 1), (tot >= 10) ? 1 : 0);
                end else begin
                    tot = 10 + va - vb;
                    op1(4'(va), 4'(vb), 1, 1'(vc), to_bcd(tot % 10, 1), (va >= vb) ? 1 : 0);
                end
            end
        end
        md = 100000000;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 200; i++) begin
                va = $urandom_range(0, 99999999);
                vb = $urandom_range(0, 99999999);
                vc = $urandom_range(0, 1);
                if (m == 0) begin
                    tot = va + vb + vc;
                    op8(32'(to_bcd(va, 8)), 32'(to_bcd(vb, 8)), 0, 1'(vc),
                        to_bcd(tot % md, 8), (tot >= md) ? 1 : 0);
                end else begin
                    tot = md + va - vb;
                    op8(32'(to_bcd(va, 8)), 32'(to_bcd(vb, 8)), 1, 1'(vc),
                        to_bcd(tot % md, 8), (va >= vb) ? 1 : 0);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
